// File: rtl/de_timing_pkg.sv
// Panel timing constants and decoder state encoding shared by the DE generator and decoder.
package de_timing_pkg;

    localparam int PANEL_WIDTH  = 480;
    localparam int PANEL_HEIGHT = 272;
    localparam int H_BLANK      = 45;
    localparam int V_BLANK      = 18;
    localparam int H_TOTAL      = PANEL_WIDTH + H_BLANK;
    localparam int V_TOTAL      = PANEL_HEIGHT + V_BLANK;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ALIGNED = 2'd1,
        ST_LOCKED  = 2'd2
    } de_dec_state_e;

    function automatic logic [8:0] sat_inc9(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/de_timing_decoder_edge.sv
// de_edge_gap_detect: registered DE, rise/fall strobes and saturating DE-low run counter.
// vblank fires in the cycle the low run reaches VGAP_MIN; gap_sat marks a rise that follows vblank.
module de_edge_gap_detect
    import de_timing_pkg::*;
#(
    parameter int VGAP_MIN = 200
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_de,
    output logic rise,
    output logic fall,
    output logic gap_sat,
    output logic vblank
);

    localparam logic [9:0] GAP_LIMIT = 10'(VGAP_MIN);

    if (VGAP_MIN <= H_BLANK || VGAP_MIN > 1023) begin : g_bad_vgap
        $error("de_edge_gap_detect: VGAP_MIN must exceed the H blank width and be at most 1023");
    end

    logic       de_q;
    logic [9:0] gap_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            de_q    <= 1'b0;
            gap_cnt <= '0;
        end else begin
            de_q <= i_de;
            if (i_de)
                gap_cnt <= '0;
            else if (gap_cnt != GAP_LIMIT)
                gap_cnt <= sat_inc10(gap_cnt);
        end
    end

    assign rise    = i_de & ~de_q;
    assign fall    = ~i_de & de_q;
    assign gap_sat = (gap_cnt == GAP_LIMIT);
    assign vblank  = ~i_de & (gap_cnt == GAP_LIMIT - 10'd1);

endmodule

// File: rtl/de_timing_decoder.sv
// DE-mode stream decoder: pixel coordinates, line/frame pulses, measured geometry and lock.
// Optional geometry checking is enabled by defining DE_DECODER_CHECK_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_SEARCH  | no vblank seen since reset; outputs and pulses held at 0
// ST_ALIGNED | frame boundaries known, waiting for a frame that matches
// ST_LOCKED  | last closed frame matched the expected geometry
module de_timing_decoder
    import de_timing_pkg::*;
#(
    parameter int EXP_WIDTH  = PANEL_WIDTH,
    parameter int EXP_HEIGHT = PANEL_HEIGHT,
    parameter int VGAP_MIN   = 200
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_de,
    input  logic [23:0] i_data,
    output logic        o_valid,
    output logic [23:0] o_data,
    output logic [8:0]  o_col,
    output logic [8:0]  o_row,
    output logic        o_line_start,
    output logic        o_frame_start,
    output logic        o_locked,
    output logic        o_err,
    output logic [9:0]  o_width,
    output logic [8:0]  o_height
);

    if (EXP_WIDTH < 1 || EXP_WIDTH > 1023 || EXP_HEIGHT < 1 || EXP_HEIGHT > 511) begin : g_bad_geometry
        $error("de_timing_decoder: expected geometry out of range");
    end

    logic rise, fall, gap_sat, vblank;

    de_edge_gap_detect #(.VGAP_MIN(VGAP_MIN)) u_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_de    (i_de),
        .rise    (rise),
        .fall    (fall),
        .gap_sat (gap_sat),
        .vblank  (vblank)
    );

    de_dec_state_e state, state_nxt;
    logic [9:0]    line_len;
    logic [8:0]    lines_cnt;
    logic          frame_open;
    logic          active, frame_rise, line_rise, frame_close;
    logic          frame_bad, err_nxt;

    assign active      = (state != ST_SEARCH);
    assign frame_rise  = rise & gap_sat;
    assign line_rise   = rise & ~gap_sat;
    assign frame_close = vblank & frame_open;

`ifdef DE_DECODER_CHECK_EN
    localparam logic [9:0] EXP_W10  = 10'(EXP_WIDTH);
    localparam logic [8:0] EXP_H9   = 9'(EXP_HEIGHT);
    localparam logic [8:0] ROW_LAST = 9'(EXP_HEIGHT - 1);

    logic mis_flag;

    // Sticky per-frame mismatch: wrong line length or a line past the last expected row.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            mis_flag <= 1'b0;
        else if (frame_close)
            mis_flag <= 1'b0;
        else if (active && ((fall && line_len != EXP_W10) || (line_rise && o_row >= ROW_LAST)))
            mis_flag <= 1'b1;
    end

    assign frame_bad = mis_flag | (lines_cnt != EXP_H9);
`else
    assign frame_bad = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            ST_SEARCH:  if (vblank) state_nxt = ST_ALIGNED;
            ST_ALIGNED: begin
                if (frame_close) begin
                    if (frame_bad)
                        err_nxt = 1'b1;
                    else
                        state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (frame_close && frame_bad) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_ALIGNED;
                end
            end
            default:    state_nxt = ST_SEARCH;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_SEARCH;
            line_len      <= '0;
            lines_cnt     <= '0;
            frame_open    <= 1'b0;
            o_valid       <= 1'b0;
            o_data        <= '0;
            o_col         <= '0;
            o_row         <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_locked      <= 1'b0;
            o_err         <= 1'b0;
            o_width       <= '0;
            o_height      <= '0;
        end else begin
            state         <= state_nxt;
            o_locked      <= (state_nxt == ST_LOCKED);
            o_err         <= err_nxt;
            o_valid       <= active & i_de;
            o_line_start  <= active & rise;
            o_frame_start <= active & frame_rise;

            if (i_de)
                o_data <= i_data;

            if (rise)
                line_len <= 10'd1;
            else if (i_de)
                line_len <= sat_inc10(line_len);

            if (active) begin
                if (rise)
                    o_col <= '0;
                else if (i_de)
                    o_col <= sat_inc9(o_col);

                if (frame_rise) begin
                    o_row      <= '0;
                    lines_cnt  <= 9'd1;
                    frame_open <= 1'b1;
                end else if (line_rise) begin
                    o_row     <= sat_inc9(o_row);
                    lines_cnt <= sat_inc9(lines_cnt);
                end

                if (fall)
                    o_width <= line_len;
            end

            if (frame_close) begin
                o_height   <= lines_cnt;
                frame_open <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_de_timing_decoder.sv
// Randomised self-checking bench for de_timing_decoder against a frame/line level reference model.
`timescale 1ns/1ps
module tb_de_timing_decoder;

    localparam int EW = 32;
    localparam int EH = 12;
    localparam int VG = 200;
    localparam int HB = 45;
`ifdef DE_DECODER_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_de;
    logic [23:0] i_data;
    logic        o_valid;
    logic [23:0] o_data;
    logic [8:0]  o_col;
    logic [8:0]  o_row;
    logic        o_line_start;
    logic        o_frame_start;
    logic        o_locked;
    logic        o_err;
    logic [9:0]  o_width;
    logic [8:0]  o_height;

    de_timing_decoder #(.EXP_WIDTH(EW), .EXP_HEIGHT(EH), .VGAP_MIN(VG)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_de          (i_de),
        .i_data        (i_data),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_col         (o_col),
        .o_row         (o_row),
        .o_line_start  (o_line_start),
        .o_frame_start (o_frame_start),
        .o_locked      (o_locked),
        .o_err         (o_err),
        .o_width       (o_width),
        .o_height      (o_height)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 = searching, 1 = aligned, 2 = locked
    int m_state, m_gap, m_row, m_lines, m_width, m_height;
    bit m_open, m_flag, m_err;

    task automatic chk_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_gap = 0; m_row = 0; m_lines = 0;
        m_width = 0; m_height = 0; m_open = 0; m_flag = 0; m_err = 0;
    endtask

    task automatic check_zero(input string tag);
        chk_val({tag, "_valid"},  o_valid, 0);
        chk_val({tag, "_data"},   o_data, 0);
        chk_val({tag, "_col"},    o_col, 0);
        chk_val({tag, "_row"},    o_row, 0);
        chk_val({tag, "_ls"},     o_line_start, 0);
        chk_val({tag, "_fs"},     o_frame_start, 0);
        chk_val({tag, "_locked"}, o_locked, 0);
        chk_val({tag, "_err"},    o_err, 0);
        chk_val({tag, "_width"},  o_width, 0);
        chk_val({tag, "_height"}, o_height, 0);
    endtask

    task automatic send_line(input int len);
        logic [23:0] d;
        int ls, fs;
        for (int c = 0; c < len; c++) begin
            ls = 0;
            fs = 0;
            if (c == 0 && m_state != 0) begin
                ls = 1;
                if (m_gap >= VG) begin
                    fs = 1; m_row = 0; m_lines = 1; m_open = 1;
                end else begin
                    if (CHECK && m_row + 1 > EH - 1) m_flag = 1;
                    m_row   = sat(m_row + 1, 511);
                    m_lines = sat(m_lines + 1, 511);
                end
            end
            m_gap  = 0;
            d      = 24'($urandom);
            i_de   = 1'b1;
            i_data = d;
            @(posedge i_clk); #1;
            if (m_state == 0) begin
                chk_val("valid_search", o_valid, 0);
                chk_val("ls_search", o_line_start, 0);
                chk_val("fs_search", o_frame_start, 0);
            end else begin
                chk_val("valid", o_valid, 1);
                chk_val("data", o_data, d);
                chk_val("col", o_col, sat(c, 511));
                chk_val("row", o_row, m_row);
                chk_val("line_start", o_line_start, ls);
                chk_val("frame_start", o_frame_start, fs);
                chk_val("err_in_line", o_err, 0);
            end
        end
        if (m_state != 0) begin
            m_width = sat(len, 1023);
            if (CHECK && len != EW) m_flag = 1;
        end
    endtask

    task automatic send_gap(input int n);
        bit mis;
        for (int i = 0; i < n; i++) begin
            i_de   = 1'b0;
            i_data = 24'($urandom);
            @(posedge i_clk); #1;
            m_gap++;
            m_err = 0;
            if (m_gap == VG) begin
                if (m_state == 0) begin
                    m_state = 1;
                end else if (m_open) begin
                    m_height = m_lines;
                    mis = CHECK && (m_flag || m_lines != EH);
                    if (mis) begin
                        m_err = 1; m_state = 1;
                    end else if (m_state == 1) begin
                        m_state = 2;
                    end
                    m_open = 0;
                    m_flag = 0;
                end
            end
            chk_val("valid_gap", o_valid, 0);
            chk_val("err", o_err, m_err);
            chk_val("locked", o_locked, (m_state == 2) ? 1 : 0);
            if (i == 0) chk_val("width", o_width, m_width);
            if (m_gap == VG) chk_val("height", o_height, m_height);
        end
    endtask

    task automatic send_frame(input int nl, input int w, input int hg, input int vg);
        for (int l = 0; l < nl; l++) begin
            send_line(w);
            if (l < nl - 1) send_gap(hg);
        end
        send_gap(vg);
    endtask

    task automatic reset_mid();
        #2 i_rst = 1'b1;
        #1 check_zero("rst_mid");
        i_de = 1'b0;
        @(posedge i_clk); #3 i_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int nl, w, hg;
        i_rst  = 1'b1;
        i_de   = 1'b0;
        i_data = '0;
        model_reset();
        #3 check_zero("reset");
        @(posedge i_clk); #3 i_rst = 1'b0;

        // initial vertical blanking, then three clean frames
        send_gap(VG + 60);
        for (int f = 0; f < 3; f++) send_frame(EH, EW, HB, VG + 60);

        // one line a pixel short, then recovery
        for (int l = 0; l < EH; l++) begin
            send_line((l == 4) ? EW - 1 : EW);
            if (l < EH - 1) send_gap(HB);
        end
        send_gap(VG + 20);
        send_frame(EH, EW, HB, VG + 20);
        send_frame(EH, EW, HB, VG);

        // one line short of the frame, then recovery
        send_frame(EH - 1, EW, HB, VG + 30);
        send_frame(EH, EW, HB, VG + 30);

        // longest horizontal gap that is still H blank
        for (int l = 0; l < EH; l++) begin
            send_line(EW);
            if (l < EH - 1) send_gap((l == 5) ? VG - 1 : HB);
        end
        send_gap(VG + 10);

        // one extra line, then clean
        send_frame(EH + 1, EW, HB, VG + 10);
        send_frame(EH, EW, HB, VG + 10);

        // wide lines: 400 px, column and width saturation
        send_frame(EH, 400, HB, VG + 10);
        send_line(600);
        send_gap(HB);
        send_line(1030);
        send_gap(VG + 5);

        // row and height saturation with one-pixel lines
        send_frame(520, 1, 1, VG + 5);
        send_frame(EH, EW, HB, VG + 5);
        send_frame(EH, EW, HB, VG + 5);

        // asynchronous reset in the middle of a frame
        for (int l = 0; l < 5; l++) begin
            send_line(EW);
            send_gap(HB);
        end
        send_line(10);
        reset_mid();
        for (int l = 0; l < 3; l++) begin
            send_line(EW);
            send_gap(HB);
        end
        send_gap(VG + 40);
        send_frame(EH, EW, HB, VG + 40);

        // randomised frames
        for (int f = 0; f < 12; f++) begin
            nl = EH;
            if ($urandom_range(0, 3) == 0) nl = EH - 2 + int'($urandom_range(0, 4));
            for (int l = 0; l < nl; l++) begin
                w  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 40)) : EW;
                hg = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, VG - 1)) : HB;
                send_line(w);
                if (l < nl - 1) send_gap(hg);
            end
            send_gap(int'($urandom_range(VG, VG + 80)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/de_timing_decoder.md
# de_timing_decoder

Receive-side counterpart of the LCD data-enable timing generator. Takes a DE-mode video stream (data enable plus 24-bit RGB) and reconstructs pixel coordinates, line and frame boundaries, and measured active geometry. It declares lock once the stream matches the expected panel geometry. It sits between a DE-mode video source (loopback from the panel driver, or an external source) and downstream pixel consumers such as capture, overlay or checksum blocks.

## Interface
- EXP_WIDTH, 480: expected active pixels per line.
- EXP_HEIGHT, 272: expected active lines per frame.
- VGAP_MIN, 200: a DE-low run of at least this many cycles is vertical blanking. Must exceed the horizontal blanking width (45) and be no more than 1023.
- i_clk  in  1  pixel clock
- i_rst  in  1  asynchronous, active-high reset
- i_de  in  1  input data enable
- i_data  in  24  input RGB pixel, valid when i_de=1
- o_valid  out  1  registered pixel strobe
- o_data  out  24  registered pixel
- o_col  out  9  column of o_data
- o_row  out  9  row of o_data
- o_line_start  out  1  pulse with first pixel of each line
- o_frame_start  out  1  pulse with pixel (0,0)
- o_locked  out  1  geometry lock
- o_err  out  1  one-cycle pulse on geometry mismatch
- o_width  out  10  last measured line length
- o_height  out  9  last measured frame height

## Operation
- The state machine has three states: SEARCH (entered on reset), ALIGNED and LOCKED. o_locked=1 only in LOCKED.
- gap_cnt (10-bit) counts consecutive i_de=0 cycles. It saturates at VGAP_MIN and clears when i_de=1.
  - Vblank event: gap_cnt reaches VGAP_MIN.
  - Any shorter gap is horizontal blanking.
- SEARCH → ALIGNED on a vblank event. In SEARCH, o_valid and all pulses are held at 0.
- The first i_de rising edge after a vblank is the frame start: row=0, col=0, o_frame_start=1 and o_line_start=1 on that pixel.
- Column counter:
  - increments on each i_de=1 cycle;
  - resets on each i_de rising edge;
  - saturates at 511.
- Row counter:
  - increments on each non-frame-start rising edge;
  - saturates at 511.
- On each i_de falling edge:
  - the line length (10-bit, saturating at 1023) is loaded into o_width;
  - the frame-mismatch flag is set if the line length ≠ EXP_WIDTH.
- On a vblank event while a frame is open:
  - o_height ← lines seen;
  - the frame is checked: mismatch = flag set, or height ≠ EXP_HEIGHT.
  - ALIGNED: no mismatch → LOCKED; mismatch → o_err, stay in ALIGNED.
  - LOCKED: mismatch → o_err, go to ALIGNED.
  - The flag clears after the check.
- A vblank event with no line since the previous vblank performs no check.
- A rising edge with gap_cnt < VGAP_MIN that would make row exceed EXP_HEIGHT-1 sets the mismatch flag. Row still saturates at 511.
- Asynchronous reset mid-frame: all counters, outputs and flags clear immediately; state goes to SEARCH.

## Timing
- All outputs are registered. Latency is 1 cycle from i_de/i_data to o_valid/o_data/o_col/o_row and the pulses.
- Reset values:
  - o_valid, o_line_start, o_frame_start, o_locked, o_err = 0;
  - o_data, o_col, o_row, o_width, o_height = 0.
- The vblank event is detected in the cycle gap_cnt becomes VGAP_MIN. o_err and state changes are visible on the following edge.
- A single-cycle i_de pulse is a line of width 1.
- No backpressure: the input must be accepted every cycle.

## Configuration
- DE_DECODER_CHECK_EN defined: geometry checking as described. o_err is generated, and LOCKED requires a matching frame.
- DE_DECODER_CHECK_EN undefined:
  - the EXP_WIDTH/EXP_HEIGHT comparisons are removed and o_err is tied to 0;
  - ALIGNED → LOCKED on the first vblank event that closes a frame containing at least one line;
  - LOCKED is left only by reset.
  - o_width and o_height are still measured.

## Structure
- Shared package de_timing_pkg holds:
  - the panel constants (width 480, height 272, H blank 45, V blank 18, H total 525, V total 290);
  - the decoder state enum (SEARCH, ALIGNED, LOCKED).
- The generator and decoder both import this package.
- One sub-module, de_edge_gap_detect, provides the registered i_de, rise/fall strobes and the saturating gap counter with the vblank event output.

## Test plan
- Generator timing (525×290 total, H blank 45, V blank 18, 480×272 active) for 3 frames → o_locked rises after the first full frame closes. o_frame_start pulses once per frame, 1 cycle after the first DE rise. The last pixel has o_col=479, o_row=271.
- Locked stream, one line shortened to 479 pixels → o_width=479. One o_err pulse at the following vblank. o_locked falls, then rises again after the next clean frame.
- Frame with 271 lines → o_height=271, o_err pulse. The state stays ALIGNED or goes from LOCKED to ALIGNED.
- DE-low gap of VGAP_MIN-1 cycles mid-frame → treated as H blank: row continues, no frame start.
- Assert i_rst at row 100 → all outputs are 0 immediately. After release, no o_valid until a vblank has been seen.
- Build with DE_DECODER_CHECK_EN undefined, 400-pixel lines → lock after the first frame, o_err stays 0, o_width=400.
